// File: rtl/spi_boot_loader.sv
// spi_boot_loader
//
// Boot sequencer that owns the SPI controller byte interface after reset.
// It reads a program image from SPI flash with the READ command (0x03)
// and writes it word by word into instruction memory through the imem
// programming port. The core is held in reset for the whole load.
//
// Ports:
//   clk, Rst               system clock, asynchronous active-low reset
//   start, word_count      load request pulse and number of 32-bit words
//   spi_wr, spi_din        push one TX byte into the SPI controller
//   spi_ignore_response    controller drops the RX byte of this write
//   spi_buffer_full        TX buffer has no room
//   spi_data_avail, spi_rd RX byte present / pop it
//   spi_dout               RX byte
//   spi_cs_hold            keep flash chip-select asserted
//   imem_prog_ena, imem_en imem programming strobe and enable
//   imem_addr, imem_din    imem byte address and write data
//   core_hold              hold the core in reset
//   done, error            sticky completion / timeout status
module spi_boot_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_0000,
  parameter int unsigned TIMEOUT    = 4096,
  parameter bit          AUTOBOOT   = 1'b1
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [15:0] word_count,
  output logic        spi_wr,
  output logic [7:0]  spi_din,
  output logic        spi_ignore_response,
  input  logic        spi_buffer_full,
  input  logic        spi_data_avail,
  output logic        spi_rd,
  input  logic [7:0]  spi_dout,
  output logic        spi_cs_hold,
  output logic        imem_prog_ena,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SEND,
    RECV,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [31:0] TLIMIT = 32'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] count;
  logic [15:0] idx;
  logic [1:0]  cmd_cnt;
  logic [1:0]  lane;
  logic [31:0] word;
  logic [31:0] tcnt;
  logic        boot_pending;
  logic [7:0]  cmd_byte;

  // READ command followed by the 24-bit flash address, MSB first
  always_comb begin
    cmd_byte = 8'h03;
    case (cmd_cnt)
      2'd0: cmd_byte = 8'h03;
      2'd1: cmd_byte = FLASH_BASE[23:16];
      2'd2: cmd_byte = FLASH_BASE[15:8];
      2'd3: cmd_byte = FLASH_BASE[7:0];
      default: cmd_byte = 8'h03;
    endcase
  end

  // Single FSM with registered outputs. spi_buffer_full is sampled on the
  // edge that launches a write, so a write is only issued when the buffer
  // reported room on that edge. boot_pending makes the first cycle after
  // reset release behave like a start pulse when AUTOBOOT is set.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state               <= IDLE;
      count               <= 16'd0;
      idx                 <= 16'd0;
      cmd_cnt             <= 2'd0;
      lane                <= 2'd0;
      word                <= 32'd0;
      tcnt                <= 32'd0;
      boot_pending        <= AUTOBOOT;
      spi_wr              <= 1'b0;
      spi_din             <= 8'd0;
      spi_ignore_response <= 1'b0;
      spi_rd              <= 1'b0;
      spi_cs_hold         <= 1'b0;
      imem_prog_ena       <= 1'b0;
      imem_en             <= 1'b0;
      imem_addr           <= 32'd0;
      imem_din            <= 32'd0;
      core_hold           <= AUTOBOOT;
      done                <= 1'b0;
      error               <= 1'b0;
    end else begin
      spi_wr        <= 1'b0;
      spi_rd        <= 1'b0;
      imem_prog_ena <= 1'b0;
      imem_en       <= 1'b0;

      case (state)
        IDLE, DONE, ERROR: begin
          if (start || boot_pending) begin
            boot_pending <= 1'b0;
            count        <= word_count;
            idx          <= 16'd0;
            cmd_cnt      <= 2'd0;
            lane         <= 2'd0;
            error        <= 1'b0;
            spi_cs_hold  <= 1'b0;
            // an empty image completes immediately and releases the core
            if (word_count == 16'd0) begin
              state     <= DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state     <= CMD;
              done      <= 1'b0;
              core_hold <= 1'b1;
            end
          end else if (state == DONE) begin
            done        <= 1'b1;
            core_hold   <= 1'b0;
            spi_cs_hold <= 1'b0;
          end
        end

        CMD: begin
          if (!spi_buffer_full) begin
            spi_wr              <= 1'b1;
            spi_din             <= cmd_byte;
            spi_ignore_response <= 1'b1;
            spi_cs_hold         <= 1'b1;
            cmd_cnt             <= cmd_cnt + 2'd1;
            if (cmd_cnt == 2'd3) begin
              state <= SEND;
            end
          end
        end

        SEND: begin
          if (!spi_buffer_full) begin
            spi_wr              <= 1'b1;
            spi_din             <= 8'h00;
            spi_ignore_response <= 1'b0;
            tcnt                <= 32'd0;
            state               <= RECV;
          end
        end

        // bytes arrive little-endian: lane 0 fills word[7:0]
        RECV: begin
          if (spi_data_avail) begin
            spi_rd                   <= 1'b1;
            word[{lane, 3'b000} +: 8] <= spi_dout;
            lane                     <= lane + 2'd1;
            state                    <= (lane == 2'd3) ? WRITE : SEND;
          end else if (tcnt == TLIMIT) begin
            state       <= ERROR;
            error       <= 1'b1;
            spi_cs_hold <= 1'b0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end

        WRITE: begin
          imem_prog_ena <= 1'b1;
          imem_en       <= 1'b1;
          imem_addr     <= IMEM_BASE + {14'd0, idx, 2'b00};
          imem_din      <= word;
          idx           <= idx + 16'd1;
          if ((idx + 16'd1) == count) begin
            state <= DONE;
          end else begin
            state <= SEND;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_boot_loader.sv
// tb_spi_boot_loader
//
// Bench for spi_boot_loader. A small SPI/flash model answers every dummy
// byte with the next image byte a few cycles later. Expected TX bytes and
// imem writes are queued when a load is requested and popped as the DUT
// produces them.
module tb_spi_boot_loader;

  localparam int          LAT        = 3;
  localparam logic [23:0] FLASH_BASE = 24'h100000;
  localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [15:0] word_count;
  logic        spi_wr;
  logic [7:0]  spi_din;
  logic        spi_ignore_response;
  logic        spi_buffer_full;
  logic        spi_data_avail = 1'b0;
  logic        spi_rd;
  logic [7:0]  spi_dout = 8'h00;
  logic        spi_cs_hold;
  logic        imem_prog_ena;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;
  logic        core_hold;
  logic        done;
  logic        error;

  spi_boot_loader #(
    .FLASH_BASE(FLASH_BASE),
    .IMEM_BASE (IMEM_BASE),
    .TIMEOUT   (16),
    .AUTOBOOT  (1'b1)
  ) dut (
    .clk                (clk),
    .Rst                (Rst),
    .start              (start),
    .word_count         (word_count),
    .spi_wr             (spi_wr),
    .spi_din            (spi_din),
    .spi_ignore_response(spi_ignore_response),
    .spi_buffer_full    (spi_buffer_full),
    .spi_data_avail     (spi_data_avail),
    .spi_rd             (spi_rd),
    .spi_dout           (spi_dout),
    .spi_cs_hold        (spi_cs_hold),
    .imem_prog_ena      (imem_prog_ena),
    .imem_en            (imem_en),
    .imem_addr          (imem_addr),
    .imem_din           (imem_din),
    .core_hold          (core_hold),
    .done               (done),
    .error              (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0]  exp_tx[$];
  logic [63:0] exp_imem[$];
  logic [7:0]  flash_q[$];
  logic [7:0]  rx_fifo[$];
  logic [31:0] img[0:5];

  bit          respond_en = 1'b1;
  int          resp_timer = -1;
  logic [7:0]  resp_byte  = 8'h00;
  logic [8:0]  tx_e;
  logic [63:0] im_e;

  int cycle = 0, wr_count = 0, rd_count = 0, prog_count = 0;
  int last_prog_cycle = -100, dummy_cycle = -100;
  int done_rise = -1, core_fall = -1, cs_fall = -1, err_rise = -1;
  logic prev_done = 1'b0, prev_core = 1'b1, prev_cs = 1'b0, prev_err = 1'b0;
  logic full_prev = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Queue one load: expected TX bytes, flash contents and imem writes.
  task automatic applyStimulus(input int nwords, input int first, input bit pulse);
    done_rise = -1;
    core_fall = -1;
    cs_fall   = -1;
    word_count = 16'(nwords);
    if (nwords > 0) begin
      exp_tx.push_back({1'b1, 8'h03});
      exp_tx.push_back({1'b1, FLASH_BASE[23:16]});
      exp_tx.push_back({1'b1, FLASH_BASE[15:8]});
      exp_tx.push_back({1'b1, FLASH_BASE[7:0]});
    end
    for (int i = 0; i < nwords; i++) begin
      logic [31:0] w;
      w = img[first + i];
      for (int b = 0; b < 4; b++) begin
        exp_tx.push_back({1'b0, 8'h00});
        flash_q.push_back(w[b*8 +: 8]);
      end
      exp_imem.push_back({IMEM_BASE + 32'(i * 4), w});
    end
    if (pulse) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic check_done_edge(input string tag);
    checkOutput({tag, "_core_fall"}, core_fall, done_rise);
    checkOutput({tag, "_cs_fall"}, cs_fall, done_rise);
    checkOutput({tag, "_done_after_write"}, done_rise, last_prog_cycle + 1);
    checkOutput({tag, "_tx_left"}, exp_tx.size(), 0);
    checkOutput({tag, "_imem_left"}, exp_imem.size(), 0);
  endtask

  // SPI controller / flash model and output scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    cycle++;
    if (!Rst) begin
      rx_fifo.delete();
      resp_timer = -1;
    end else begin
      if (resp_timer > 0) begin
        resp_timer--;
        if (resp_timer == 0) begin
          rx_fifo.push_back(resp_byte);
          resp_timer = -1;
        end
      end
      if (spi_rd) begin
        rd_count++;
        if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
        else checkOutput("rd_empty", 1, 0);
      end
      if (spi_wr) begin
        wr_count++;
        checkOutput("wr_while_full", full_prev, 1'b0);
        if (exp_tx.size() == 0) begin
          checkOutput("tx_unexpected", 1, 0);
        end else begin
          tx_e = exp_tx.pop_front();
          checkOutput("tx_byte", {spi_ignore_response, spi_din}, tx_e);
        end
        if (!spi_ignore_response) begin
          dummy_cycle = cycle;
          if (respond_en) begin
            resp_byte  = (flash_q.size() > 0) ? flash_q.pop_front() : 8'hFF;
            resp_timer = LAT;
          end
        end
      end
      if (imem_prog_ena) begin
        prog_count++;
        last_prog_cycle = cycle;
        checkOutput("imem_en", imem_en, 1'b1);
        if (exp_imem.size() == 0) begin
          checkOutput("imem_unexpected", 1, 0);
        end else begin
          im_e = exp_imem.pop_front();
          checkOutput("imem_addr", imem_addr, im_e[63:32]);
          checkOutput("imem_data", imem_din, im_e[31:0]);
        end
      end
    end
    if (done && !prev_done) done_rise = cycle;
    if (!core_hold && prev_core) core_fall = cycle;
    if (!spi_cs_hold && prev_cs) cs_fall = cycle;
    if (error && !prev_err) err_rise = cycle;
    prev_done = done;
    prev_core = core_hold;
    prev_cs   = spi_cs_hold;
    prev_err  = error;
    full_prev = spi_buffer_full;
    spi_data_avail = (rx_fifo.size() > 0);
    spi_dout       = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wbase, pbase, rbase, n;
    img[0] = 32'h0000_0013;
    img[1] = 32'h0000_006F;
    img[2] = 32'hDEAD_BEEF;
    img[3] = 32'h00C0_FFEE;
    img[4] = 32'h1234_5678;
    img[5] = 32'hA5A5_5A5A;
    Rst = 1'b1;
    start = 1'b0;
    word_count = 16'd0;
    spi_buffer_full = 1'b0;
    #2 Rst = 1'b0;
    #1;
    checkOutput("rst_spi_wr", spi_wr, 1'b0);
    checkOutput("rst_core_hold", core_hold, 1'b1);
    checkOutput("rst_cs_hold", spi_cs_hold, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_error", error, 1'b0);

    // autoboot of a two-word image
    applyStimulus(2, 0, 1'b0);
    @(negedge clk); Rst = 1'b1;
    wait_done("boot", 500);
    checkOutput("boot_core_hold", core_hold, 1'b0);
    checkOutput("boot_cs_hold", spi_cs_hold, 1'b0);
    check_done_edge("boot");

    // buffer full for 5 cycles while the command is going out
    wbase = wr_count;
    applyStimulus(1, 2, 1'b1);
    n = 0;
    while (wr_count < wbase + 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    spi_buffer_full = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    spi_buffer_full = 1'b0;
    checkOutput("full_wr_count", wr_count - wbase, 2);
    wait_done("full", 500);
    check_done_edge("full");

    // no flash response: timeout into ERROR
    respond_en = 1'b0;
    err_rise = -1;
    exp_tx.push_back({1'b1, 8'h03});
    exp_tx.push_back({1'b1, FLASH_BASE[23:16]});
    exp_tx.push_back({1'b1, FLASH_BASE[15:8]});
    exp_tx.push_back({1'b1, FLASH_BASE[7:0]});
    exp_tx.push_back({1'b0, 8'h00});
    word_count = 16'd1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!error && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("to_error", error, 1'b1);
    checkOutput("to_latency", err_rise - dummy_cycle, 16);
    checkOutput("to_core_hold", core_hold, 1'b1);
    checkOutput("to_cs_hold", spi_cs_hold, 1'b0);
    checkOutput("to_done", done, 1'b0);
    checkOutput("to_tx_left", exp_tx.size(), 0);
    respond_en = 1'b1;

    // empty image from ERROR: done on the next cycle, no traffic
    wbase = wr_count;
    pbase = prog_count;
    word_count = 16'd0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); #1;
    checkOutput("zero_done", done, 1'b1);
    checkOutput("zero_error", error, 1'b0);
    checkOutput("zero_core_hold", core_hold, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("zero_wr", wr_count - wbase, 0);
    checkOutput("zero_prog", prog_count - pbase, 0);

    // start pulsed while in SEND is dropped
    rbase = rd_count;
    applyStimulus(2, 3, 1'b1);
    n = 0;
    while (rd_count == rbase && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    start = 1'b1;
    word_count = 16'd5;
    @(posedge clk); #1 start = 1'b0;
    word_count = 16'd2;
    wait_done("ign", 500);
    check_done_edge("ign");

    // reset during the second word, then autoboot again
    pbase = prog_count;
    rbase = rd_count;
    applyStimulus(2, 4, 1'b1);
    n = 0;
    while ((prog_count < pbase + 1 || rd_count < rbase + 5) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    #2 Rst = 1'b0;
    #1;
    checkOutput("mid_spi_wr", spi_wr, 1'b0);
    checkOutput("mid_spi_din", spi_din, 8'h00);
    checkOutput("mid_ignore", spi_ignore_response, 1'b0);
    checkOutput("mid_spi_rd", spi_rd, 1'b0);
    checkOutput("mid_cs_hold", spi_cs_hold, 1'b0);
    checkOutput("mid_prog_ena", imem_prog_ena, 1'b0);
    checkOutput("mid_imem_en", imem_en, 1'b0);
    checkOutput("mid_imem_addr", imem_addr, 32'd0);
    checkOutput("mid_imem_din", imem_din, 32'd0);
    checkOutput("mid_done", done, 1'b0);
    checkOutput("mid_error", error, 1'b0);
    checkOutput("mid_core_hold", core_hold, 1'b1);
    exp_tx.delete();
    exp_imem.delete();
    flash_q.delete();
    applyStimulus(2, 4, 1'b0);
    @(negedge clk);
    @(negedge clk); Rst = 1'b1;
    wait_done("reboot", 500);
    check_done_edge("reboot");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
